// File: rtl/fica_pkg.sv
// fica_pkg: shared types and defaults for the FastICA sequencer.
// Holds the FSM encoding, parameter defaults and MUL pipe depth.
package fica_pkg;

  localparam int DEF_NUM_BATCH = 64;
  localparam int DEF_MAX_ITER  = 32;
  localparam int PIPE_DEPTH    = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_NORM,
    S_CHECK,
    S_FIN
  } state_t;

endpackage

// File: rtl/fica_seq_vpipe.sv
// fica_vpipe: valid shift register tracking issued blocks
// through the RAM read and the three MUL stages.
module fica_vpipe
  import fica_pkg::*;
#(
  parameter int DEPTH = PIPE_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic             flush,
  output logic [DEPTH-1:0] v
);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      v <= '0;
    end else begin
      v <= {v[DEPTH-2:0], issue};
    end
  end

endmodule

// File: rtl/fica_seq.sv
// fica_seq: FastICA iteration sequencer.
// Streams blocks, drains the MUL pipe, runs the normaliser, loops.
module fica_seq
  import fica_pkg::*;
#(
  parameter int NUM_BATCH = DEF_NUM_BATCH,
  parameter int MAX_ITER  = DEF_MAX_ITER
) (
  input  logic                         clk_seq,
  input  logic                         rstn_seq,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         src_valid,
  input  logic                         norm_done,
  input  logic                         conv_in,
  output logic [$clog2(NUM_BATCH)-1:0] batch_addr,
  output logic                         en_mul1,
  output logic                         en_mul2,
  output logic                         en_mul3,
  output logic                         en_acc,
  output logic                         acc_clr,
  output logic                         norm_start,
  output logic [7:0]                   iter_cnt,
  output logic                         busy,
  output logic                         done,
  output logic                         converged,
  output logic                         timeout
);

  localparam int AW = $clog2(NUM_BATCH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_BATCH - 1);
  localparam logic [7:0] LAST_ITER = 8'(MAX_ITER - 1);

  state_t state;
  state_t state_d;

  logic [AW-1:0]         addr_d;
  logic [7:0]            iter_d;
  logic                  conv_q;
  logic                  conv_d;
  logic                  cvg_d;
  logic                  tmo_d;
  logic                  clr_d;
  logic                  nst_d;
  logic                  issue;
  logic [PIPE_DEPTH-1:0] v;

  fica_vpipe #(
    .DEPTH(PIPE_DEPTH)
  ) u_vpipe (
    .clk  (clk_seq),
    .rst_n(rstn_seq),
    .issue(issue),
    .flush(abort),
    .v    (v)
  );

  assign en_mul1 = v[0];
  assign en_mul2 = v[1];
  assign en_mul3 = v[2];
  assign en_acc  = v[3];
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_FIN);

  always_ff @(posedge clk_seq) begin
    if (!rstn_seq) begin
      state      <= S_IDLE;
      batch_addr <= '0;
      iter_cnt   <= '0;
      conv_q     <= 1'b0;
      converged  <= 1'b0;
      timeout    <= 1'b0;
      acc_clr    <= 1'b0;
      norm_start <= 1'b0;
    end else begin
      state      <= state_d;
      batch_addr <= addr_d;
      iter_cnt   <= iter_d;
      conv_q     <= conv_d;
      converged  <= cvg_d;
      timeout    <= tmo_d;
      acc_clr    <= clr_d;
      norm_start <= nst_d;
    end
  end

  always_comb begin
    state_d = state;
    addr_d  = batch_addr;
    iter_d  = iter_cnt;
    conv_d  = conv_q;
    cvg_d   = converged;
    tmo_d   = timeout;
    clr_d   = 1'b0;
    nst_d   = 1'b0;
    issue   = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      addr_d  = '0;
      iter_d  = '0;
      conv_d  = 1'b0;
      cvg_d   = 1'b0;
      tmo_d   = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state_d = S_FILL;
            clr_d   = 1'b1;
            addr_d  = '0;
            iter_d  = '0;
            conv_d  = 1'b0;
            cvg_d   = 1'b0;
            tmo_d   = 1'b0;
          end
        end
        S_FILL: begin
          if (src_valid) begin
            issue = 1'b1;
            if (batch_addr == LAST_ADDR) begin
              addr_d  = '0;
              state_d = S_DRAIN;
            end else begin
              addr_d = batch_addr + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // wait until the last block has reached the accumulator
          if (v == '0) begin
            nst_d   = 1'b1;
            state_d = S_NORM;
          end
        end
        S_NORM: begin
          if (norm_done) begin
            conv_d  = conv_in;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (conv_q) begin
            cvg_d   = 1'b1;
            state_d = S_FIN;
          end else if (iter_cnt == LAST_ITER) begin
            tmo_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            iter_d  = iter_cnt + 8'd1;
            clr_d   = 1'b1;
            state_d = S_FILL;
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fica_seq.sv
// tb_fica_seq: directed scenarios plus random traffic, checked
// cycle by cycle against a timestamp-based reference model.
module tb_fica_seq;

  localparam int NB = 4;
  localparam int MI = 3;

  localparam int P_IDLE  = 0;
  localparam int P_FILL  = 1;
  localparam int P_DRAIN = 2;
  localparam int P_NORM  = 3;
  localparam int P_CHECK = 4;
  localparam int P_FIN   = 5;

  logic       clk_seq = 1'b0;
  logic       rstn_seq;
  logic       start;
  logic       abort;
  logic       src_valid;
  logic       norm_done;
  logic       conv_in;
  logic [1:0] batch_addr;
  logic       en_mul1;
  logic       en_mul2;
  logic       en_mul3;
  logic       en_acc;
  logic       acc_clr;
  logic       norm_start;
  logic [7:0] iter_cnt;
  logic       busy;
  logic       done;
  logic       converged;
  logic       timeout;

  fica_seq #(
    .NUM_BATCH(NB),
    .MAX_ITER (MI)
  ) dut (
    .clk_seq   (clk_seq),
    .rstn_seq  (rstn_seq),
    .start     (start),
    .abort     (abort),
    .src_valid (src_valid),
    .norm_done (norm_done),
    .conv_in   (conv_in),
    .batch_addr(batch_addr),
    .en_mul1   (en_mul1),
    .en_mul2   (en_mul2),
    .en_mul3   (en_mul3),
    .en_acc    (en_acc),
    .acc_clr   (acc_clr),
    .norm_start(norm_start),
    .iter_cnt  (iter_cnt),
    .busy      (busy),
    .done      (done),
    .converged (converged),
    .timeout   (timeout)
  );

  always #5 clk_seq = ~clk_seq;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // reference model: phase + issue timestamps
  int cyc = 0;
  int ph = P_IDLE;
  int m_addr = 0;
  int m_iter = 0;
  int last_kill = -100;
  bit m_conv = 0;
  bit m_cvg = 0;
  bit m_tmo = 0;
  bit m_clr = 0;
  bit m_nst = 0;
  bit iss_at[int];

  int cnt_acc;
  int cnt_clr;
  int cnt_nst;
  int first_acc;

  function automatic bit en_exp(input int m, input int k);
    if (last_kill > m - k) return 1'b0;
    return iss_at.exists(m - k);
  endfunction

  function automatic bit pipe_live(input int m);
    return en_exp(m, 0) | en_exp(m, 1) | en_exp(m, 2) | en_exp(m, 3);
  endfunction

  task automatic model_step();
    m_clr = 0;
    m_nst = 0;
    if (!rstn_seq || abort) begin
      ph = P_IDLE;
      m_addr = 0;
      m_iter = 0;
      m_conv = 0;
      m_cvg = 0;
      m_tmo = 0;
      last_kill = cyc;
    end else begin
      case (ph)
        P_IDLE: if (start) begin
          ph = P_FILL;
          m_clr = 1;
          m_addr = 0;
          m_iter = 0;
          m_cvg = 0;
          m_tmo = 0;
        end
        P_FILL: if (src_valid) begin
          iss_at[cyc] = 1'b1;
          m_addr = (m_addr + 1) % NB;
          if (m_addr == 0) ph = P_DRAIN;
        end
        P_DRAIN: if (!pipe_live(cyc - 1)) begin
          m_nst = 1;
          ph = P_NORM;
        end
        P_NORM: if (norm_done) begin
          m_conv = conv_in;
          ph = P_CHECK;
        end
        P_CHECK: begin
          if (m_conv) begin
            m_cvg = 1;
            ph = P_FIN;
          end else if (m_iter == MI - 1) begin
            m_tmo = 1;
            ph = P_FIN;
          end else begin
            m_iter++;
            m_clr = 1;
            ph = P_FILL;
          end
        end
        default: ph = P_IDLE;
      endcase
    end
  endtask

  function automatic logic [31:0] exp_vec();
    return {12'd0, ph != P_IDLE, ph == P_FIN, m_cvg, m_tmo,
            en_exp(cyc, 0), en_exp(cyc, 1), en_exp(cyc, 2),
            en_exp(cyc, 3), m_clr, m_nst, 8'(m_iter), 2'(m_addr)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {12'd0, busy, done, converged, timeout,
            en_mul1, en_mul2, en_mul3, en_acc,
            acc_clr, norm_start, iter_cnt, batch_addr};
  endfunction

  task automatic clr_cnt();
    cnt_acc = 0;
    cnt_clr = 0;
    cnt_nst = 0;
    first_acc = -1;
  endtask

  task automatic tick();
    @(posedge clk_seq);
    cyc++;
    model_step();
    #1;
    check_eq("outs", dut_vec(), exp_vec());
    check_eq("excl", {31'd0, converged & timeout}, 0);
    cnt_acc += int'(en_acc);
    cnt_clr += int'(acc_clr);
    cnt_nst += int'(norm_start);
    if (en_acc && first_acc < 0) first_acc = cyc;
  endtask

  // mode 0: src_valid=1, mode 1: toggling; hammer holds start while busy
  task automatic run_to_done(input int budget, input int mode,
                             input bit hammer);
    int k = 0;
    while (!done && k < budget) begin
      src_valid = (mode == 0) ? 1'b1 : ((k % 2) == 0);
      start = hammer & busy;
      tick();
      k++;
    end
    start = 1'b0;
    check_eq("done_seen", {31'd0, done}, 1);
  endtask

  initial begin
    int s_edge;
    int k;
    bit sv_pat [5];
    rstn_seq = 0;
    start = 0;
    abort = 0;
    src_valid = 0;
    norm_done = 0;
    conv_in = 0;
    clr_cnt();
    tick();
    tick();
    check_eq("rst_zero", dut_vec(), 0);
    rstn_seq = 1;
    tick();

    // single converging iteration
    clr_cnt();
    norm_done = 1;
    conv_in = 1;
    src_valid = 1;
    start = 1;
    tick();
    s_edge = cyc;
    start = 0;
    run_to_done(200, 0, 0);
    check_eq("s1_acc", cnt_acc, NB);
    check_eq("s1_lat", first_acc - s_edge, 4);
    check_eq("s1_nst", cnt_nst, 1);
    check_eq("s1_cvg", {31'd0, converged}, 1);
    check_eq("s1_tmo", {31'd0, timeout}, 0);
    check_eq("s1_iter", iter_cnt, 0);
    tick();
    check_eq("s1_hold", {30'd0, converged, busy}, 2);

    // toggling src_valid
    clr_cnt();
    start = 1;
    tick();
    start = 0;
    run_to_done(200, 1, 0);
    check_eq("s2_acc", cnt_acc, NB);
    check_eq("s2_cvg", {31'd0, converged}, 1);
    tick();

    // never converges
    clr_cnt();
    conv_in = 0;
    start = 1;
    tick();
    start = 0;
    run_to_done(400, 0, 0);
    check_eq("s3_clr", cnt_clr, 3);
    check_eq("s3_tmo", {31'd0, timeout}, 1);
    check_eq("s3_cvg", {31'd0, converged}, 0);
    check_eq("s3_iter", iter_cnt, 2);
    check_eq("s3_acc", cnt_acc, 3 * NB);
    tick();

    // abort in DRAIN with v=0110
    sv_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    conv_in = 1;
    start = 1;
    tick();
    start = 0;
    k = 0;
    while (!(ph == P_DRAIN && !en_exp(cyc, 0) && en_exp(cyc, 1) &&
             en_exp(cyc, 2) && !en_exp(cyc, 3)) && k < 50) begin
      src_valid = (k < 5) ? sv_pat[k] : 1'b1;
      tick();
      k++;
    end
    check_eq("s4_v", {28'd0, en_acc, en_mul3, en_mul2, en_mul1}, 4'b0110);
    abort = 1;
    tick();
    abort = 0;
    check_eq("s4_idle", {28'd0, busy, done, en_mul1 | en_mul2,
                         en_mul3 | en_acc}, 0);
    check_eq("s4_addr", batch_addr, 0);
    clr_cnt();
    start = 1;
    tick();
    start = 0;
    run_to_done(200, 0, 0);
    check_eq("s4_acc", cnt_acc, NB);
    check_eq("s4_cvg", {31'd0, converged}, 1);
    tick();

    // reset in FILL at batch_addr=2, then start while busy
    start = 1;
    src_valid = 1;
    tick();
    start = 0;
    k = 0;
    while (!(ph == P_FILL && m_addr == 2) && k < 20) begin
      tick();
      k++;
    end
    check_eq("s5_addr", batch_addr, 2);
    rstn_seq = 0;
    start = 1;
    tick();
    check_eq("s5_zero", dut_vec(), 0);
    rstn_seq = 1;
    start = 0;
    tick();
    clr_cnt();
    start = 1;
    tick();
    run_to_done(200, 0, 1);
    check_eq("s5_clr", cnt_clr, 1);
    check_eq("s5_acc", cnt_acc, NB);
    tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rstn_seq = ($urandom_range(0, 127) != 0);
      abort = ($urandom_range(0, 63) == 0);
      start = ($urandom_range(0, 3) == 0);
      src_valid = ($urandom_range(0, 3) != 0);
      norm_done = ($urandom_range(0, 2) == 0);
      conv_in = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fica_seq.md
FICA_SEQ -- requirements
Module: fica_seq

Interface
REQ-001 SHALL have parameter NUM_BATCH, default 64, meaning 4x4 sample blocks per iteration (2..1024).
REQ-002 SHALL have parameter MAX_ITER, default 32, meaning iteration limit (1..255).
REQ-003 SHALL have port clk_seq, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rstn_seq, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: begin a run (sampled in IDLE only).
REQ-006 SHALL have port abort, input, 1 bit: synchronous cancel of the current run.
REQ-007 SHALL have port src_valid, input, 1 bit: sample block at batch_addr is available.
REQ-008 SHALL have port norm_done, input, 1 bit: the normaliser has finished w update.
REQ-009 SHALL have port conv_in, input, 1 bit: convergence flag, valid while norm_done=1.
REQ-010 SHALL have port batch_addr, output, clog2(NUM_BATCH) bits: sample-block read address.
REQ-011 SHALL have port en_mul1, en_mul2, en_mul3, en_acc, output, 1 bit each: per-stage enables for the zTw, square, cube and accumulate stages.
REQ-012 SHALL have port acc_clr, output, 1 bit: clear the accumulator.
REQ-013 SHALL have port norm_start, output, 1 bit: start the normaliser.
REQ-014 SHALL have port iter_cnt, output, 8 bits: current iteration index.
REQ-015 SHALL have ports busy, done, converged, timeout, output, 1 bit each: status.

Function
REQ-016 SHALL implement the states IDLE, FILL, DRAIN, NORM, CHECK and FIN.
REQ-017 IDLE: start=1 SHALL go to FILL, pulse acc_clr for 1 cycle, and clear iter_cnt, batch_addr, converged and timeout.
REQ-018 FILL: an issue SHALL occur in every cycle with src_valid=1; on issue batch_addr increments; the issue with batch_addr=NUM_BATCH-1 SHALL wrap batch_addr to 0 and go to DRAIN.
REQ-019 FILL with src_valid=0 SHALL issue nothing, hold batch_addr and inject a bubble.
REQ-020 A 4-bit valid shift register v SHALL update as v[0]<=issue, v[k]<=v[k-1].
REQ-021 Enable mapping SHALL be en_mul1=v[0], en_mul2=v[1], en_mul3=v[2], en_acc=v[3]; latency from issue to en_acc SHALL be 4 cycles, matching 1-cycle RAM read plus three 1-cycle MUL stages.
REQ-022 DRAIN SHALL stay until v==0, then pulse norm_start for 1 cycle and go to NORM.
REQ-023 NORM SHALL wait for norm_done=1, latch conv_in and go to CHECK.
REQ-024 CHECK, latched conv=1: SHALL set converged and go to FIN.
REQ-025 CHECK, conv=0 with iter_cnt==MAX_ITER-1: SHALL set timeout and go to FIN.
REQ-026 CHECK, all other cases: SHALL increment iter_cnt, pulse acc_clr and go to FILL.
REQ-027 FIN SHALL pulse done for 1 cycle and go to IDLE; converged and timeout SHALL hold until the next start.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 start outside IDLE SHALL be ignored.
REQ-030 abort SHALL have priority over all transitions; the next cycle is IDLE with v=0, batch_addr=0, no done, and flags cleared.
REQ-031 norm_done=1 outside NORM SHALL be ignored.
REQ-032 converged and timeout SHALL never both be 1.

Reset
REQ-033 rstn_seq=0 at a clock edge SHALL put the block in IDLE with every output 0, v=0, batch_addr=0 and iter_cnt=0.
REQ-034 Reset mid-run SHALL behave as abort, with no done pulse.

Structure
REQ-035 The state encoding, MAX_ITER/NUM_BATCH defaults and PIPE_DEPTH=4 SHALL live in the shared package fica_pkg.
REQ-036 The valid shift register SHALL be the sub-module fica_vpipe (parameter DEPTH, with issue, flush and v outputs).

Verification
REQ-037 NUM_BATCH=4, src_valid=1, conv_in=1 on the first norm_done: 4 issues on consecutive cycles; en_acc high for 4 cycles, starting 4 cycles after the first issue; then one norm_start; then done with converged=1 and iter_cnt=0.
REQ-038 src_valid toggles 1,0,1,0: bubbles appear in en_mul1..en_acc at matching offsets; total en_acc cycles = NUM_BATCH.
REQ-039 MAX_ITER=3, conv_in always 0: exactly 3 acc_clr pulses; then done with timeout=1, converged=0, iter_cnt=2.
REQ-040 abort during DRAIN with v=4'b0110: next cycle IDLE, all enables 0, no done; a following start runs normally.
REQ-041 rstn_seq=0 for 1 cycle during FILL at batch_addr=2: all outputs 0 next cycle; start while busy is ignored.
